// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine with a fixed 34-cycle latency.
// It works on operand magnitudes and applies sign fix-up and special cases in a final FIX cycle.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_val,
   input  logic [XLEN-1:0] i_rs2_val,
   input  logic [4:0]      i_rd_addr,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result,
   output logic [4:0]      o_rd_out,
   output logic            o_we_out
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_a;
   logic [XLEN-1:0]   r_rs1;
   logic [2*XLEN-1:0] r_acc;
   logic              r_negA;
   logic              r_negB;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_rd;

   logic              w_accept;
   logic              w_sgnA;
   logic              w_sgnB;
   logic              w_negA;
   logic              w_negB;
   logic [XLEN-1:0]   w_magA;
   logic [XLEN-1:0]   w_magB;
   logic [XLEN:0]     w_mulSum;
   logic [XLEN:0]     w_remShift;
   logic [XLEN:0]     w_diff;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic              w_divZero;
   logic [XLEN-1:0]   w_fixResult;

   assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;

   // MULH, MULHSU, DIV and REM treat rs1 as signed; only MULH, DIV and REM treat rs2 as signed.
   assign w_sgnA = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                   (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
   assign w_sgnB = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
   assign w_negA = w_sgnA && i_rs1_val[XLEN-1];
   assign w_negB = w_sgnB && i_rs2_val[XLEN-1];
   assign w_magA = w_negA ? (~i_rs1_val + 1'b1) : i_rs1_val;
   assign w_magB = w_negB ? (~i_rs2_val + 1'b1) : i_rs2_val;

   // The accumulator holds product-high:multiplier, or remainder:quotient while dividing.
   assign w_mulSum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
   assign w_remShift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
   assign w_diff     = w_remShift - {1'b0, r_a};

   assign w_prod    = (r_negA ^ r_negB) ? (~r_acc + 1'b1) : r_acc;
   assign w_quo     = (r_negA ^ r_negB) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
   assign w_rem     = r_negA ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
   assign w_divZero = (r_a == '0);

   always_comb begin
      w_fixResult = '0;
      case (r_op)
         3'b000:                 w_fixResult = w_prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fixResult = w_prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_fixResult = w_divZero ? '1 : w_quo;
         default:                w_fixResult = w_divZero ? r_rs1 : w_rem;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  w_nextState = i_start ? S_RUN : S_IDLE;
         S_RUN:   w_nextState = (r_cnt == CW'(XLEN-1)) ? S_FIX : S_RUN;
         S_FIX:   w_nextState = S_DONE;
         S_DONE:  w_nextState = i_start ? S_RUN : S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Datapath: capture on accept, one shift-add or restoring step per RUN cycle, result latched in FIX.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_rs1    <= '0;
         r_acc    <= '0;
         r_negA   <= 1'b0;
         r_negB   <= 1'b0;
         r_result <= '0;
         r_rd     <= '0;
      end else if (w_accept) begin
         r_cnt  <= '0;
         r_op   <= i_funct3;
         r_a    <= w_magB;
         r_rs1  <= i_rs1_val;
         r_acc  <= {{XLEN{1'b0}}, w_magA};
         r_negA <= w_negA;
         r_negB <= w_negB;
         r_rd   <= i_rd_addr;
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_op[2]) begin
            if (!w_diff[XLEN]) begin
               r_acc <= {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
               r_acc <= {w_remShift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end
         end else begin
            r_acc <= {w_mulSum, r_acc[XLEN-1:1]};
         end
      end else if (r_state == S_FIX) begin
         r_result <= w_fixResult;
      end
   end

   assign o_busy   = (r_state == S_RUN) || (r_state == S_FIX);
   assign o_done   = (r_state == S_DONE);
   assign o_result = r_result;
   assign o_rd_out = r_rd;
   assign o_we_out = o_done && (r_rd != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, fixed latency, busy window, ignored inputs,
// x0 writeback suppression, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [4:0]  rdAddr;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rdOut;
   logic        weOut;

   int nChecks = 0;
   int nFail   = 0;
   int lat;
   int busyCnt;
   int doneCnt;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_funct3  (funct3),
      .i_rs1_val (rs1),
      .i_rs2_val (rs2),
      .i_rd_addr (rdAddr),
      .o_busy    (busy),
      .o_done    (done),
      .o_result  (result),
      .o_rd_out  (rdOut),
      .o_we_out  (weOut)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present one request in the cycle before an edge; returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd);
      @(negedge clk);
      start  = 1'b1;
      funct3 = f;
      rs1    = a;
      rs2    = b;
      rdAddr = rd;
      @(posedge clk);
      #1;
      start  = 1'b0;
      funct3 = 3'b101;
      rs1    = 32'hDEAD_BEEF;
      rs2    = 32'h1234_5678;
      rdAddr = 5'd31;
   endtask

   // Counts edges after accept until done; optionally pulses start at two chosen cycles.
   task automatic waitDone(input int injA, input int injB);
      lat     = 0;
      busyCnt = (busy === 1'b1) ? 1 : 0;
      while (lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy === 1'b1) busyCnt++;
         if (done === 1'b1) break;
         if (lat == injA || lat == injB) begin
            start  = 1'b1;
            funct3 = 3'b000;
            rs1    = 32'h0000_0055;
            rs2    = 32'h0000_0003;
            rdAddr = 5'd9;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expected);
      applyStimulus(f, a, b, 5'd1);
      waitDone(-1, -1);
      checkOutput({tag, " result"}, result, expected);
      checkOutput({tag, " latency"}, 32'(lat), 32'd33);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      funct3 = 3'b000;
      rs1    = '0;
      rs2    = '0;
      rdAddr = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset done", {31'b0, done}, 32'd0);
      checkOutput("reset we", {31'b0, weOut}, 32'd0);
      checkOutput("reset result", result, 32'd0);
      checkOutput("reset rd", {27'b0, rdOut}, 32'd0);

      // Reset and start together: reset must win.
      @(negedge clk);
      start = 1'b1;
      funct3 = 3'b000;
      rs1 = 32'd3;
      rs2 = 32'd4;
      rdAddr = 5'd6;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
      checkOutput("rst+start busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("rst+start idle", {31'b0, busy}, 32'd0);

      // MUL with full writeback and timing checks.
      applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
      waitDone(-1, -1);
      checkOutput("mul result", result, 32'hFFFF_FFEB);
      checkOutput("mul latency", 32'(lat), 32'd33);
      checkOutput("mul busy cycles", 32'(busyCnt), 32'd33);
      checkOutput("mul we", {31'b0, weOut}, 32'd1);
      checkOutput("mul rd", {27'b0, rdOut}, 32'd5);
      @(posedge clk);
      #1;
      checkOutput("mul done pulse", {31'b0, done}, 32'd0);

      runOp("mulh min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      runOp("mulhu max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      runOp("mulhsu -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      runOp("mulh -1*1", 3'b001, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
      runOp("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      runOp("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      runOp("rem 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1);
      runOp("div 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
      runOp("remu 5/0", 3'b111, 32'd5, 32'd0, 32'd5);
      runOp("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      runOp("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

      // Start pulses mid-operation must be ignored; result then holds while idle.
      applyStimulus(3'b000, 32'd6, 32'd7, 5'd7);
      waitDone(3, 20);
      checkOutput("ignore result", result, 32'd42);
      checkOutput("ignore latency", 32'(lat), 32'd33);
      checkOutput("ignore rd", {27'b0, rdOut}, 32'd7);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("hold result", result, 32'd42);
      checkOutput("hold busy", {31'b0, busy}, 32'd0);

      // Destination x0 suppresses the write enable.
      applyStimulus(3'b011, 32'd10, 32'd10, 5'd0);
      waitDone(-1, -1);
      checkOutput("x0 latency", 32'(lat), 32'd33);
      checkOutput("x0 done", {31'b0, done}, 32'd1);
      checkOutput("x0 we", {31'b0, weOut}, 32'd0);

      // Back-to-back: second request issued in the DONE cycle of the first.
      applyStimulus(3'b101, 32'd100, 32'd7, 5'd2);
      waitDone(-1, -1);
      checkOutput("divu 100/7", result, 32'd14);
      checkOutput("divu latency", 32'(lat), 32'd33);
      applyStimulus(3'b111, 32'd100, 32'd7, 5'd3);
      checkOutput("b2b busy", {31'b0, busy}, 32'd1);
      waitDone(-1, -1);
      checkOutput("remu 100/7", result, 32'd2);
      checkOutput("b2b latency", 32'(lat), 32'd33);
      checkOutput("b2b rd", {27'b0, rdOut}, 32'd3);

      // Reset at counter 10 of a DIV aborts it.
      applyStimulus(3'b100, 32'd1000, 32'd7, 5'd4);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("abort busy", {31'b0, busy}, 32'd0);
      checkOutput("abort result", result, 32'd0);
      doneCnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) doneCnt++;
      end
      checkOutput("abort no done", 32'(doneCnt), 32'd0);
      runOp("mulhu 2*3", 3'b011, 32'd2, 32'd3, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative RV32M multiply/divide unit.
- Sits between the register file read ports (`rs1_val`/`rs2_val`) and the register file write port: on `done` it drives the write data, destination address and write enable for one cycle.
- Runs as a fixed-latency multi-cycle engine: the core stalls while `busy` is high and takes writeback from this unit when `done` pulses.

## Interface
- `XLEN`, 32 — operand/result width; the arithmetic rules below are defined for 32.
- `clk`  in  1  — single clock, all state on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request; sampled only in IDLE or DONE.
- `funct3`  in  3  — op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val`  in  XLEN  — operand A, captured on the accepting edge.
- `rs2_val`  in  XLEN  — operand B, captured on the accepting edge.
- `rd_addr`  in  5  — destination register, captured on the accepting edge.
- `busy`  out  1  — high in RUN and FIX.
- `done`  out  1  — one-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  — writeback data; holds its value until the next DONE.
- `rd_out`  out  5  — captured `rd_addr`; holds its value until the next accept.
- `we_out`  out  1  — equals `done && (rd_out != 0)`.

## Operation
- **States:** IDLE, RUN, FIX, DONE.
- **IDLE/DONE:**
  - `start`=1 → capture `funct3`, operands and `rd_addr`; clear the iteration counter; go to RUN.
  - Otherwise DONE→IDLE and IDLE→IDLE.
- **RUN:**
  - 32 iterations, one per cycle, counter 0..31.
  - After the counter reaches 31, go to FIX.
- **FIX:** apply sign correction, special cases and result select; go to DONE.
- **Operand conditioning at capture:**
  - Signed operands (DIV/REM/MULH both; MULHSU rs1 only) are converted to magnitude, and sign flags are stored.
  - All other operands are treated as unsigned.
- **Multiply:**
  - Unsigned 32×32 shift-add into a 64-bit accumulator.
  - In FIX, negate the 64-bit product if the operand signs differ.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- **Divide:**
  - Restoring division on magnitudes, producing a 32-bit quotient and 32-bit remainder.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- **Special cases (resolved in FIX, latency unchanged):**
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- **Inputs while busy:** `start`, operands, `funct3` and `rd_addr` are ignored while `busy`=1. No queueing.

## Timing
- **Latency:** accept edge E0 → RUN for cycles after E0..E31 → FIX after E32 → DONE after E33.
  - `done`=1 for exactly the cycle between E33 and E34, fixed for every op.
- **`busy`:** low in the cycle `start` is presented; high from after E0 through after E32 (33 cycles); low in DONE.
- **Back-to-back:** `start` in the DONE cycle is accepted. The next `done` follows 34 cycles later with no idle gap.
- **Reset values:** state IDLE, `busy`=0, `done`=0, `we_out`=0, `result`=0, `rd_out`=0, counter=0.
- **Reset mid-operation:** `rst` wins over everything.
  - The operation is aborted and no `done` is produced.
  - In the cycle after the reset edge, `busy`=0.
  - Simultaneous `rst` and `start` → reset.

## Test plan
- **MUL latency and writeback:** MUL 7 × 0xFFFFFFFD, `rd_addr`=5.
  - `result`=0xFFFFFFEB and `we_out`=1 with `rd_out`=5.
  - `done` exactly 34 cycles after the accept edge; `busy` high for 33 cycles.
- **High multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULH 0xFFFFFFFF × 1 → 0xFFFFFFFF.
- **Divide signs:**
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; REM 7/−2 → 1.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- **Special cases:**
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - All complete in 34 cycles.
- **Ignored inputs and x0:** pulse `start` with new operands at cycles 3 and 20 of an operation.
  - No effect; the original result is returned.
  - Op with `rd_addr`=0: `done`=1, `we_out`=0.
  - Back-to-back `start` in the DONE cycle → second `done` 34 cycles later.
- **Reset:** assert `rst` at counter 10 of a DIV.
  - Next cycle `busy`=0, `result`=0; no `done` ever appears for that op.
  - A following MULHU 2×3 → 0 completes normally.
